jtframe_romrq_arb: RTL



---
 rtl/jtframe_romrq_arb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/jtframe_romrq_arb.sv
// SDRAM read arbiter for the ROM request slots: one read in flight at a time.
// Define JTFRAME_ARB_RR_EN for round-robin arbitration (fixed priority otherwise).
module jtframe_romrq_arb #(
    parameter int SLOTS   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              downloading,
    input  logic [SLOTS-1:0]  slot_req,
    input  logic [22*SLOTS-1:0] slot_addr,
    output logic [SLOTS-1:0]  slot_we,
    output logic              slot_dok,
    output logic [31:0]       slot_din,
    output logic              sdram_req,
    output logic [21:0]       sdram_addr,
    input  logic              sdram_ack,
    input  logic              sdram_rdy,
    input  logic [31:0]       sdram_din,
    output logic              err
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_ACK  = 2'd1;
    localparam logic [1:0] WAIT_DATA = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;

    localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
    localparam logic [SLOTS-1:0] ONE = SLOTS'(1);

    logic [1:0]    state;
    logic [7:0]    wdog;
    logic [PW-1:0] win;
    logic          found;
    logic          wd_hit;

    assign wd_hit = (TIMEOUT != 0) && (wdog == WD_LAST);

`ifdef JTFRAME_ARB_RR_EN
    logic [PW-1:0] rr_ptr;

    // Scan downwards so the slot closest after the pointer wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = SLOTS; k >= 1; k--) begin
            if (slot_req[(int'(rr_ptr) + k) % SLOTS]) begin
                found = 1'b1;
                win   = PW'((int'(rr_ptr) + k) % SLOTS);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= PW'(SLOTS - 1);
        end else if (state == IDLE && !downloading && found) begin
            rr_ptr <= win;
        end
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slot_req[i]) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wdog       <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            slot_we    <= '0;
            slot_dok   <= 1'b0;
            slot_din   <= '0;
            err        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    wdog <= '0;
                    if (!downloading && found) begin
                        sdram_req  <= 1'b1;
                        sdram_addr <= slot_addr[22*int'(win) +: 22];
                        slot_we    <= ONE << win;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    wdog <= wdog + 8'd1;
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        if (sdram_rdy) begin
                            slot_din <= sdram_din;
                            slot_dok <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end else if (wd_hit) begin
                        sdram_req <= 1'b0;
                        slot_we   <= '0;
                        err       <= 1'b1;
                        wdog      <= '0;
                        state     <= IDLE;
                    end
                end
                WAIT_DATA: begin
                    wdog <= wdog + 8'd1;
                    if (sdram_rdy) begin
                        slot_din <= sdram_din;
                        slot_dok <= 1'b1;
                        state    <= DONE;
                    end else if (wd_hit) begin
                        slot_we <= '0;
                        err     <= 1'b1;
                        wdog    <= '0;
                        state   <= IDLE;
                    end
                end
                DONE: begin
                    // Owner sees its data this cycle; its request drops before IDLE samples
                    slot_dok <= 1'b0;
                    slot_we  <= '0;
                    wdog     <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
